imem_loader: RTL and testbench

//  Boot-time writer for the instruction ROM. Takes a byte stream (valid/ready) from a host link,

---
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a length-prefixed, XOR-checksummed
// byte stream into little-endian 32-bit imem writes and holds the core until it verifies.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [AW:0] WIDX_ONE = 1;

  state_e state_q, state_d;

  logic [15:0]   len_q, len_d;
  logic [AW:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    acc_q, acc_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          accept;
  logic          restart;
  logic          word_end;
  logic          last_word;
  logic          len_over;
  logic          len_zero;
  logic [15:0]   len_full;
  logic [AW:0]   word_idx_inc;
  logic [23:0]   lanes;

  assign accept       = in_valid & in_ready;
  assign restart      = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
  assign len_full     = {in_data, len_q[7:0]};
  assign len_over     = {1'b0, len_full} > 17'(DEPTH);
  assign len_zero     = (len_full == 16'd0);
  assign word_end     = accept & (state_q == S_DATA) & (byte_idx_q == 2'd3);
  assign word_idx_inc = word_idx_q + WIDX_ONE;
  assign last_word    = (32'(word_idx_inc) == 32'(len_q));

  // Lower three bytes of the word in flight; the 4th byte goes straight to wdata.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= 8'd0;
      end else if (accept && (state_q == S_DATA) && (byte_idx_q == 2'(gi))) begin
        lane_q <= in_data;
      end
    end

    assign lanes[8*gi +: 8] = lane_q;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (accept) state_d = S_LEN1;
      end
      S_LEN1: begin
        if (accept) begin
          if (len_over)      state_d = S_ERR;
          else if (len_zero) state_d = S_CSUM;
          else               state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_end && last_word) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    if (restart) begin
      len_d      = 16'd0;
      word_idx_d = '0;
      byte_idx_d = 2'd0;
      acc_d      = 8'd0;
    end else if (accept) begin
      // The checksum byte itself is compared, never folded in.
      if (state_q != S_CSUM) acc_d = acc_q ^ in_data;
      case (state_q)
        S_LEN0: len_d[7:0]  = in_data;
        S_LEN1: len_d[15:8] = in_data;
        S_DATA: begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            word_idx_d = word_idx_inc;
            we_d       = 1'b1;
            waddr_d    = word_idx_q[AW-1:0];
            wdata_d    = {in_data, lanes};
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= 16'd0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      acc_q      <= 8'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
    end else begin
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams images with random gaps and checks
// every write and the final status against a stream-level reference model.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data  = 8'd0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [7:0]  stream_q[$];
  bit          end_q[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  int          we_cyc_q[$];
  bit          exp_done;
  bit          exp_err;
  int          used;
  logic [31:0] shadow [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Reference: interpret the stream by its format rules and predict writes and outcome.
  task automatic model_stream();
    int n;
    logic [7:0] x;
    end_q.delete();
    exp_wa.delete();
    exp_wd.delete();
    n = int'({stream_q[1], stream_q[0]});
    end_q.push_back(1'b0);
    end_q.push_back(1'b0);
    if (n > DEPTH) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      used     = 2;
      return;
    end
    x = stream_q[0] ^ stream_q[1];
    for (int w = 0; w < n; w++) begin
      exp_wa.push_back(32'(w));
      exp_wd.push_back({stream_q[2+4*w+3], stream_q[2+4*w+2], stream_q[2+4*w+1], stream_q[2+4*w]});
      for (int k = 0; k < 4; k++) begin
        end_q.push_back(k == 3);
        x ^= stream_q[2+4*w+k];
      end
    end
    end_q.push_back(1'b0);
    exp_done = (stream_q[2+4*n] == x);
    exp_err  = !exp_done;
    used     = 3 + 4*n;
  endtask

  task automatic build_image(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(n[7:0]);
    stream_q.push_back(n[15:8]);
    if (n > DEPTH) return;
    x = n[7:0] ^ n[15:8];
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      x ^= b;
    end
    stream_q.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  // Entered and left at posedge+1.
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit word_end, input int gap);
    bit acc;
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    acc      = 1'b0;
    t        = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) chk("hs_timeout", 32'd1, 32'd0);
    else if (word_end) we_cyc_q.push_back(cyc);
  endtask

  task automatic run_session(input string name, input int gapmax, input int poke_at);
    model_stream();
    we_cyc_q.delete();
    start_pulse();
    chk({name, "/start_busy"}, 32'(busy), 32'd1);
    chk({name, "/start_hold"}, 32'(cpu_hold), 32'd1);
    chk({name, "/start_clr"}, {30'd0, done, err}, 32'd0);
    for (int i = 0; i < used; i++) begin
      if (i == poke_at) begin
        start_pulse();
        chk({name, "/poke_busy"}, 32'(busy), 32'd1);
      end
      send_byte(stream_q[i], end_q[i], $urandom_range(0, gapmax));
    end
    repeat (2) @(negedge clk);
    chk({name, "/done"}, 32'(done), 32'(exp_done));
    chk({name, "/err"}, 32'(err), 32'(exp_err));
    chk({name, "/cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({name, "/busy_end"}, 32'(busy), 32'd0);
    chk({name, "/ready_end"}, 32'(in_ready), 32'd0);
    chk({name, "/writes_left"}, 32'(exp_wa.size() + we_cyc_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "/in_ready"}, 32'(in_ready), 32'd0);
    chk({name, "/busy"}, 32'(busy), 32'd0);
    chk({name, "/done"}, 32'(done), 32'd0);
    chk({name, "/err"}, 32'(err), 32'd0);
    chk({name, "/cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({name, "/we"}, 32'(imem_we), 32'd0);
    chk({name, "/waddr"}, 32'(imem_waddr), 32'd0);
    chk({name, "/wdata"}, imem_wdata, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (we_cyc_q.size() == 0 || exp_wa.size() == 0) begin
        chk("we_unexpected", 32'd1, 32'd0);
      end else begin
        chk("we_cycle", 32'(cyc), 32'(we_cyc_q.pop_front()));
        chk("waddr", 32'(imem_waddr), exp_wa.pop_front());
        chk("wdata", imem_wdata, exp_wd.pop_front());
        shadow[imem_waddr] = imem_wdata;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;

    #2 rst_n = 1'b0;
    #2 chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    run_session("case1", 0, -1);

    stream_q[10] = 8'h74;
    run_session("bad_csum", 0, -1);

    stream_q = '{8'h01, 8'h01};
    run_session("len257", 0, -1);

    stream_q = '{8'h00, 8'h00, 8'h00};
    run_session("len0", 0, -1);
    build_image(1, 1'b0);
    run_session("one_word", 2, -1);

    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    run_session("gaps", 5, -1);

    for (int r = 0; r < 12; r++) begin
      n   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 2000)) : int'($urandom_range(1, 10));
      bad = ($urandom_range(0, 3) == 0);
      build_image(n, bad);
      run_session("rand", 3, -1);
    end

    build_image(DEPTH, 1'b0);
    run_session("full_depth", 0, -1);

    // Abort after the 5th data byte: word 0 must already be out, then reset.
    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
    model_stream();
    we_cyc_q.delete();
    start_pulse();
    for (int i = 0; i < 7; i++) send_byte(stream_q[i], end_q[i], 0);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midload");
    chk("midload/word0", shadow[0], 32'h00500093);
    exp_wa.delete();
    exp_wd.delete();
    we_cyc_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset/in_ready", 32'(in_ready), 32'd0);
    chk("post_reset/cpu_hold", 32'(cpu_hold), 32'd1);
    @(posedge clk); #1;

    run_session("reload_poke", 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
